// File: rtl/apple_placer.sv
// apple_placer: owns the registered snake playfield (3-bit cells, 0 = empty),
// applies game-logic cell writes, tracks the number of empty cells and commits
// an apple at the free position offered by the apple generator.
module apple_placer #(
    parameter logic [7:0] SIZE_X     = 8'd10,
    parameter logic [7:0] SIZE_Y     = 8'd10,
    parameter int         FIELD_SIZE = int'(SIZE_X) * int'(SIZE_Y),
    parameter int         FIELD_BITS = FIELD_SIZE * 3,
    parameter int         SBITS      = $clog2(FIELD_SIZE),
    parameter int         POSBITS    = $clog2(FIELD_BITS),
    parameter logic [2:0] APPLE_CODE = 3'd7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [POSBITS-1:0]    wr_pos,
    input  logic [2:0]            wr_cell,
    output logic                  wr_err,
    input  logic                  apple_req,
    input  logic [POSBITS-1:0]    apple_pos,
    output logic                  apple_done,
    output logic                  apple_fail,
    output logic [POSBITS-1:0]    apple_at,
    output logic                  busy,
    output logic [SBITS:0]        empty_cnt,
    output logic [FIELD_BITS-1:0] field
);

    localparam logic [0:0]   IDLE     = 1'b0;
    localparam logic [0:0]   CHECK    = 1'b1;
    localparam logic [SBITS:0] CNT_FULL = (SBITS+1)'(FIELD_SIZE);

    // True when pos is the bit offset of an existing cell (in range, multiple of 3).
    function automatic logic pos_ok(input logic [POSBITS-1:0] pos);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FIELD_SIZE; i++) begin
            hit = hit | (pos == POSBITS'(i * 3));
        end
        return hit;
    endfunction

    // Cell code at bit offset pos; 0 when pos addresses no cell.
    function automatic logic [2:0] get_cell(input logic [FIELD_BITS-1:0] f,
                                            input logic [POSBITS-1:0]    pos);
        logic [2:0] code;
        code = 3'b000;
        for (int i = 0; i < FIELD_SIZE; i++) begin
            code = code | ((pos == POSBITS'(i * 3)) ? f[i*3 +: 3] : 3'b000);
        end
        return code;
    endfunction

    // Field with the cell at bit offset pos replaced by code.
    function automatic logic [FIELD_BITS-1:0] put_cell(input logic [FIELD_BITS-1:0] f,
                                                       input logic [POSBITS-1:0]    pos,
                                                       input logic [2:0]            code);
        logic [FIELD_BITS-1:0] r;
        r = f;
        for (int i = 0; i < FIELD_SIZE; i++) begin
            r[i*3 +: 3] = (pos == POSBITS'(i * 3)) ? code : f[i*3 +: 3];
        end
        return r;
    endfunction

    logic [0:0]            state_r, state_s;
    logic [FIELD_BITS-1:0] field_r, field_s;
    logic [SBITS:0]        cnt_r, cnt_s;
    logic [POSBITS-1:0]    apple_at_r, apple_at_s;
    logic                  wr_err_r, wr_err_s;
    logic                  done_r, done_s;
    logic                  fail_r, fail_s;

    logic                  wr_hit_s;
    logic [2:0]            wr_old_s;
    logic                  apple_hit_s;
    logic [2:0]            apple_old_s;

    // Decode of the write and apple target cells against the current field.
    always_comb begin
        wr_hit_s    = pos_ok(wr_pos);
        wr_old_s    = get_cell(field_r, wr_pos);
        apple_hit_s = pos_ok(apple_pos);
        apple_old_s = get_cell(field_r, apple_pos);
    end

    // Next-state logic: IDLE arbitrates clear > write > apple_req, CHECK commits or rejects the apple.
    always_comb begin
        state_s    = state_r;
        field_s    = field_r;
        cnt_s      = cnt_r;
        apple_at_s = apple_at_r;
        wr_err_s   = 1'b0;
        done_s     = 1'b0;
        fail_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear) begin
                    field_s = '0;
                    cnt_s   = CNT_FULL;
                end else if (wr_valid) begin
                    if (wr_hit_s) begin
                        field_s = put_cell(field_r, wr_pos, wr_cell);
                        if ((wr_old_s == 3'd0) && (wr_cell != 3'd0)) begin
                            cnt_s = cnt_r - (SBITS+1)'(1);
                        end else if ((wr_old_s != 3'd0) && (wr_cell == 3'd0)) begin
                            cnt_s = cnt_r + (SBITS+1)'(1);
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end else begin
                        wr_err_s = 1'b1;
                    end
                end else if (apple_req) begin
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                state_s = IDLE;
                if ((cnt_r == (SBITS+1)'(0)) || !apple_hit_s || (apple_old_s != 3'd0)) begin
                    fail_s = 1'b1;
                end else begin
                    field_s    = put_cell(field_r, apple_pos, APPLE_CODE);
                    cnt_s      = cnt_r - (SBITS+1)'(1);
                    apple_at_s = apple_pos;
                    done_s     = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, field and pulse registers; reset aborts any pending placement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            field_r    <= '0;
            cnt_r      <= CNT_FULL;
            apple_at_r <= '0;
            wr_err_r   <= 1'b0;
            done_r     <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            field_r    <= field_s;
            cnt_r      <= cnt_s;
            apple_at_r <= apple_at_s;
            wr_err_r   <= wr_err_s;
            done_r     <= done_s;
            fail_r     <= fail_s;
        end
    end

    assign wr_ready   = (state_r == IDLE);
    assign busy       = (state_r == CHECK);
    assign field      = field_r;
    assign empty_cnt  = cnt_r;
    assign apple_at   = apple_at_r;
    assign wr_err     = wr_err_r;
    assign apple_done = done_r;
    assign apple_fail = fail_r;

endmodule

// File: tb/tb_apple_placer.sv
// Scoreboard bench for apple_placer: stimulus updates a cell-array model and
// queues the expected pulse events; a negedge monitor pops and compares them.
module tb_apple_placer;

    localparam int NC = 100;
    localparam int FB = 300;
    localparam int PB = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [PB-1:0] wr_pos = '0;
    logic [2:0]    wr_cell = 3'd0;
    logic          wr_err;
    logic          apple_req = 1'b0;
    logic [PB-1:0] apple_pos = '0;
    logic          apple_done;
    logic          apple_fail;
    logic [PB-1:0] apple_at;
    logic          busy;
    logic [7:0]    empty_cnt;
    logic [FB-1:0] field;

    apple_placer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pos(wr_pos), .wr_cell(wr_cell),
        .wr_err(wr_err), .apple_req(apple_req), .apple_pos(apple_pos),
        .apple_done(apple_done), .apple_fail(apple_fail), .apple_at(apple_at),
        .busy(busy), .empty_cnt(empty_cnt), .field(field)
    );

    always #5 clk = ~clk;

    // Reference model: one integer per cell plus the last apple offset.
    int cells [NC];
    int model_at;

    typedef struct {
        int            kind;   // 0 wr_err, 1 apple_done, 2 apple_fail
        logic [FB-1:0] f;
        int            cnt;
        int            at;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int zeros();
        int z = 0;
        foreach (cells[i]) if (cells[i] == 0) z++;
        return z;
    endfunction

    function automatic logic [FB-1:0] model_field();
        logic [FB-1:0] f = '0;
        foreach (cells[i]) f[i*3 +: 3] = 3'(cells[i]);
        return f;
    endfunction

    function automatic bit valid_pos(int p);
        return (p < FB) && (p % 3 == 0);
    endfunction

    task automatic check(string name, logic [FB-1:0] act, logic [FB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int kind);
        exp_t e;
        e.kind = kind; e.f = model_field(); e.cnt = zeros(); e.at = model_at;
        sb.push_back(e);
    endtask

    task automatic check_state(string name);
        check({name, "_field"}, field, model_field());
        check({name, "_cnt"}, FB'(empty_cnt), FB'(zeros()));
    endtask

    task automatic model_reset();
        foreach (cells[i]) cells[i] = 0;
        model_at = 0;
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        automatic int np = int'(wr_err) + int'(apple_done) + int'(apple_fail);
        automatic int kind = apple_done ? 1 : (apple_fail ? 2 : 0);
        exp_t e;
        if (np > 1) begin
            n_checks++; n_errors++;
            $display("FAIL pulse_excl: got %0d pulses expected 1", np);
        end
        if (np > 0) begin
            if (sb.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
            end else begin
                e = sb.pop_front();
                check("mon_kind", FB'(kind), FB'(e.kind));
                check("mon_field", field, e.f);
                check("mon_cnt", FB'(empty_cnt), FB'(e.cnt));
                check("mon_at", FB'(apple_at), FB'(e.at));
            end
        end
    end

    task automatic do_write(int p, int code);
        wr_valid = 1'b1; wr_pos = PB'(p); wr_cell = 3'(code);
        if (valid_pos(p)) cells[p/3] = code;
        else push(0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        check_state("write");
    endtask

    function automatic int apple_model(int p);
        if (zeros() > 0 && valid_pos(p) && cells[p/3] == 0) begin
            cells[p/3] = 7; model_at = p; return 1;
        end
        return 2;
    endfunction

    task automatic do_apple(int p);
        apple_req = 1'b1; apple_pos = PB'(p);
        @(posedge clk); #1;
        apple_req = 1'b0;
        check("busy_check", FB'(busy), FB'(1));
        check("ready_check", FB'(wr_ready), FB'(0));
        push(apple_model(p));
        @(posedge clk); #1;
        check("busy_after", FB'(busy), FB'(0));
        check_state("apple");
    endtask

    task automatic do_clear(bit with_write);
        clear = 1'b1; wr_valid = with_write; wr_pos = PB'(0); wr_cell = 3'd4;
        model_reset_cells();
        @(posedge clk); #1;
        clear = 1'b0; wr_valid = 1'b0;
        check_state("clear");
    endtask

    task automatic model_reset_cells();
        foreach (cells[i]) cells[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check("rst_field", field, '0);
        check("rst_cnt", FB'(empty_cnt), FB'(100));
        check("rst_ready", FB'(wr_ready), FB'(1));
        check("rst_busy", FB'(busy), FB'(0));
        check("rst_pulses", FB'({wr_err, apple_done, apple_fail}), FB'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write / overwrite / erase.
        do_write(0, 2);
        check("cell0", FB'(field[2:0]), FB'(2));
        check("cnt99", FB'(empty_cnt), FB'(99));
        do_write(0, 5);
        check("cnt_overwrite", FB'(empty_cnt), FB'(99));
        do_write(0, 0);
        check("cnt_erase", FB'(empty_cnt), FB'(100));

        // Apple at offset 15.
        do_apple(15);
        check("apple15_cell", FB'(field[17:15]), FB'(7));
        check("apple15_at", FB'(apple_at), FB'(15));

        // Invalid write offsets.
        do_write(300, 3);
        do_write(4, 3);
        do_write(511, 1);

        // Write and request together: write first, apple two cycles later.
        wr_valid = 1'b1; wr_pos = PB'(30); wr_cell = 3'd3;
        apple_req = 1'b1; apple_pos = PB'(45);
        cells[10] = 3;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        check("wa_busy0", FB'(busy), FB'(0));
        check_state("wa_write");
        @(posedge clk); #1;
        apple_req = 1'b0;
        check("wa_busy1", FB'(busy), FB'(1));
        push(apple_model(45));
        @(posedge clk); #1;
        check_state("wa_apple");

        // Clear during CHECK is ignored; the apple still lands.
        apple_req = 1'b1; apple_pos = PB'(60);
        @(posedge clk); #1;
        apple_req = 1'b0; clear = 1'b1;
        push(apple_model(60));
        @(posedge clk); #1;
        clear = 1'b0;
        check_state("clr_in_check");

        // Clear in IDLE drops a same-cycle write.
        do_clear(1'b1);

        // Reset during CHECK: immediate reset, no done pulse.
        do_write(90, 6);
        apple_req = 1'b1; apple_pos = PB'(93);
        @(posedge clk); #1;
        apple_req = 1'b0;
        rst_n = 1'b0; #1;
        model_reset();
        check_state("midrst");
        check("midrst_busy", FB'(busy), FB'(0));
        check("midrst_at", FB'(apple_at), FB'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized mix of operations.
        for (int k = 0; k < 200; k++) begin
            automatic int op = $urandom_range(0, 9);
            automatic int p = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511)
                                                          : 3 * $urandom_range(0, 99);
            if (op < 5) do_write(p, $urandom_range(0, 7));
            else if (op < 9) do_apple(p);
            else do_clear(1'b0);
        end

        // Full field: apple must fail.
        do_clear(1'b0);
        for (int i = 0; i < NC; i++) do_write(3 * i, 1);
        check("full_cnt", FB'(empty_cnt), FB'(0));
        do_apple(3 * $urandom_range(0, 99));
        check("full_cnt_after", FB'(empty_cnt), FB'(0));
        do_clear(1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", FB'(sb.size()), FB'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
